// File: rtl/riscv_i32_debug_master_pkg.sv
// Shared types for the RISC-V debug target bus: op codes, bus payloads, response codes and master FSM states.
package riscv_i32_debug_types;

    localparam int unsigned SEL_W   = 6;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned ARG_W   = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RESP_W  = 2;
    localparam int unsigned FLAGS_W = 3;

    // Known debug ops; any other 4-bit code is forwarded to the bus untouched
    typedef enum logic [OP_W-1:0] {
        DBG_OP_NONE        = 4'd0,
        DBG_OP_CONTROL     = 4'd1,
        DBG_OP_WRITE_DATA0 = 4'd2
    } t_dbg_op;

    // Status returned to the host when no target answered or the select was illegal
    localparam logic [RESP_W-1:0] DBG_RESP_TIMEOUT = 2'h3;

    // Mask value that compares every select bit in the targets
    localparam logic [SEL_W-1:0] DBG_MASK_ALL = 6'h3F;

    // Master-to-target payload
    typedef struct packed {
        logic              valid;
        logic [SEL_W-1:0]  select;
        logic [SEL_W-1:0]  mask;
        logic [OP_W-1:0]   op;
        logic [ARG_W-1:0]  arg;
        logic [DATA_W-1:0] data;
    } t_debug_mst;

    // Target-to-master payload (wire-ORed across all targets)
    typedef struct packed {
        logic              valid;
        logic [SEL_W-1:0]  selected;
        logic              halted;
        logic              resumed;
        logic              hit_breakpoint;
        logic              op_was_none;
        logic [RESP_W-1:0] resp;
        logic [DATA_W-1:0] data;
        logic              attention;
    } t_debug_tgt;

    typedef enum logic [1:0] {
        FSM_IDLE    = 2'd0,
        FSM_ISSUE   = 2'd1,
        FSM_WAIT    = 2'd2,
        FSM_RESPOND = 2'd3
    } t_dbg_master_fsm;

endpackage

// File: rtl/riscv_i32_debug_master.sv
// Debug bus initiator: turns one host request into a single debug_mst cycle, collects the matching
// debug_tgt response (or times out), and tracks target attention while the bus is idle.
module riscv_i32_debug_master
    import riscv_i32_debug_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SEL_W-1:0]    req_select,
    input  logic [OP_W-1:0]     req_op,
    input  logic [ARG_W-1:0]    req_arg,
    input  logic [DATA_W-1:0]   req_data,

    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [RESP_W-1:0]   resp_status,
    output logic [DATA_W-1:0]   resp_data,
    output logic [FLAGS_W-1:0]  resp_flags,

    output logic                attention,

    output logic                debug_mst__valid,
    output logic [SEL_W-1:0]    debug_mst__select,
    output logic [SEL_W-1:0]    debug_mst__mask,
    output logic [OP_W-1:0]     debug_mst__op,
    output logic [ARG_W-1:0]    debug_mst__arg,
    output logic [DATA_W-1:0]   debug_mst__data,

    input  logic                debug_tgt__valid,
    input  logic [SEL_W-1:0]    debug_tgt__selected,
    input  logic                debug_tgt__halted,
    input  logic                debug_tgt__resumed,
    input  logic                debug_tgt__hit_breakpoint,
    input  logic                debug_tgt__op_was_none,
    input  logic [RESP_W-1:0]   debug_tgt__resp,
    input  logic [DATA_W-1:0]   debug_tgt__data,
    input  logic                debug_tgt__attention
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    t_dbg_master_fsm     state_q;
    t_debug_mst          mst_q;
    t_debug_tgt          tgt;
    logic [CNT_W-1:0]    cnt_q;
    logic                req_ready_q;
    logic                resp_valid_q;
    logic [RESP_W-1:0]   resp_status_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic [FLAGS_W-1:0]  resp_flags_q;
    logic                attention_q;
    logic                attn_ok_q;
    logic                bus_idle;
    logic                tgt_hit;
    logic                unused_tgt;

    // Gather the target bus into one payload
    assign tgt = {debug_tgt__valid, debug_tgt__selected, debug_tgt__halted, debug_tgt__resumed,
                  debug_tgt__hit_breakpoint, debug_tgt__op_was_none, debug_tgt__resp,
                  debug_tgt__data, debug_tgt__attention};

    // op_was_none is informational only; the host sees the raw status instead
    assign unused_tgt = tgt.op_was_none;

    // Idle bus means every target is free to drive the attention line
    assign bus_idle = (mst_q.select == '0) && (mst_q.mask == '0);
    assign tgt_hit  = tgt.valid && (tgt.selected == mst_q.select);

    // Request/response FSM, bus drive, timeout counter and attention sampling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FSM_IDLE;
            mst_q         <= '0;
            cnt_q         <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_status_q <= '0;
            resp_data_q   <= '0;
            resp_flags_q  <= '0;
            attention_q   <= 1'b0;
            attn_ok_q     <= 1'b1;
        end else begin
            attn_ok_q <= bus_idle;
            if (attn_ok_q) begin
                attention_q <= tgt.attention;
            end

            unique case (state_q)
                FSM_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        if (req_select == '0) begin
                            // Illegal select: answer immediately without touching the bus
                            resp_valid_q  <= 1'b1;
                            resp_status_q <= DBG_RESP_TIMEOUT;
                            resp_data_q   <= '0;
                            resp_flags_q  <= '0;
                            state_q       <= FSM_RESPOND;
                        end else begin
                            mst_q.valid  <= 1'b1;
                            mst_q.select <= req_select;
                            mst_q.mask   <= DBG_MASK_ALL;
                            mst_q.op     <= req_op;
                            mst_q.arg    <= req_arg;
                            mst_q.data   <= req_data;
                            state_q      <= FSM_ISSUE;
                        end
                    end
                end

                FSM_ISSUE: begin
                    // The ISSUE cycle counts as the first cycle waited
                    mst_q.valid <= 1'b0;
                    cnt_q       <= CNT_W'(1);
                    state_q     <= FSM_WAIT;
                end

                FSM_WAIT: begin
                    if (tgt_hit) begin
                        resp_valid_q  <= 1'b1;
                        resp_status_q <= tgt.resp;
                        resp_data_q   <= tgt.data;
                        resp_flags_q  <= {tgt.hit_breakpoint, tgt.resumed, tgt.halted};
                        mst_q         <= '0;
                        state_q       <= FSM_RESPOND;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_valid_q  <= 1'b1;
                        resp_status_q <= DBG_RESP_TIMEOUT;
                        resp_data_q   <= '0;
                        resp_flags_q  <= '0;
                        mst_q         <= '0;
                        state_q       <= FSM_RESPOND;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                FSM_RESPOND: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= FSM_IDLE;
                    end
                end

                default: begin
                    state_q <= FSM_IDLE;
                end
            endcase
        end
    end

    assign req_ready         = req_ready_q;
    assign resp_valid        = resp_valid_q;
    assign resp_status       = resp_status_q;
    assign resp_data         = resp_data_q;
    assign resp_flags        = resp_flags_q;
    assign attention         = attention_q;
    assign debug_mst__valid  = mst_q.valid;
    assign debug_mst__select = mst_q.select;
    assign debug_mst__mask   = mst_q.mask;
    assign debug_mst__op     = mst_q.op;
    assign debug_mst__arg    = mst_q.arg;
    assign debug_mst__data   = mst_q.data;

endmodule

// File: tb/tb_riscv_i32_debug_master.sv
// Self-checking bench for riscv_i32_debug_master: directed scenarios plus randomized transactions
// checked against a transaction-level expectation of latency, response and attention behaviour.
module tb_riscv_i32_debug_master;
    import riscv_i32_debug_types::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [5:0]  req_select;
    logic [3:0]  req_op;
    logic [15:0] req_arg;
    logic [31:0] req_data;
    logic        resp_valid, resp_ready;
    logic [1:0]  resp_status;
    logic [31:0] resp_data;
    logic [2:0]  resp_flags;
    logic        attention;
    logic        mst_valid;
    logic [5:0]  mst_select, mst_mask;
    logic [3:0]  mst_op;
    logic [15:0] mst_arg;
    logic [31:0] mst_data;
    logic        tgt_valid;
    logic [5:0]  tgt_selected;
    logic        tgt_halted, tgt_resumed, tgt_hbp, tgt_none;
    logic [1:0]  tgt_resp;
    logic [31:0] tgt_data;
    logic        tgt_attention;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    riscv_i32_debug_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .req_valid                (req_valid),
        .req_ready                (req_ready),
        .req_select               (req_select),
        .req_op                   (req_op),
        .req_arg                  (req_arg),
        .req_data                 (req_data),
        .resp_valid               (resp_valid),
        .resp_ready               (resp_ready),
        .resp_status              (resp_status),
        .resp_data                (resp_data),
        .resp_flags               (resp_flags),
        .attention                (attention),
        .debug_mst__valid         (mst_valid),
        .debug_mst__select        (mst_select),
        .debug_mst__mask          (mst_mask),
        .debug_mst__op            (mst_op),
        .debug_mst__arg           (mst_arg),
        .debug_mst__data          (mst_data),
        .debug_tgt__valid         (tgt_valid),
        .debug_tgt__selected      (tgt_selected),
        .debug_tgt__halted        (tgt_halted),
        .debug_tgt__resumed       (tgt_resumed),
        .debug_tgt__hit_breakpoint(tgt_hbp),
        .debug_tgt__op_was_none   (tgt_none),
        .debug_tgt__resp          (tgt_resp),
        .debug_tgt__data          (tgt_data),
        .debug_tgt__attention     (tgt_attention)
    );

    // Count one comparison and report it when observed differs from expected
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tgt_quiet();
        tgt_valid = 1'b0; tgt_selected = '0; tgt_halted = 1'b0; tgt_resumed = 1'b0;
        tgt_hbp = 1'b0; tgt_none = 1'b0; tgt_resp = '0; tgt_data = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_payload"}, {resp_status, resp_flags, resp_data[26:0]}, 0);
        check({tag, "_resp_data"}, resp_data, 0);
        check({tag, "_attention"}, attention, 0);
        check({tag, "_mst_ctl"}, {mst_valid, mst_select, mst_mask, mst_op, mst_arg}, 0);
        check({tag, "_mst_data"}, mst_data, 0);
    endtask

    // One host transaction. d = WAIT cycle in which the target answers (0 = never),
    // stray = WAIT cycle with a reply from a different target (0 = none), hold = cycles resp_ready stays low.
    task automatic run_txn(input logic [5:0] sel, input logic [3:0] op, input logic [15:0] arg,
                           input logic [31:0] data, input int d, input logic [1:0] rsp,
                           input logic [31:0] rdata, input logic [2:0] rflags,
                           input int stray, input int hold);
        logic        a0;
        int          lat;
        int          lat_exp;
        logic [1:0]  exp_st;
        logic [31:0] exp_data;
        logic [2:0]  exp_fl;
        logic [5:0]  stray_sel;

        stray_sel = (sel == 6'd7) ? 6'd9 : 6'd7;
        // Idle bus: attention follows the target line one cycle later
        a0 = 1'($urandom_range(0, 1));
        tgt_attention = a0;
        @(negedge clk);
        check("attn_follow", attention, a0);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);

        req_valid = 1'b1; req_select = sel; req_op = op; req_arg = arg; req_data = data;
        @(negedge clk);
        req_valid = 1'b0;
        req_select = 6'($urandom); req_op = 4'($urandom); req_arg = 16'($urandom); req_data = $urandom;

        if (sel == 6'd0) begin
            check("illegal_no_issue", mst_valid, 0);
            @(negedge clk);
            check("illegal_no_issue2", mst_valid, 0);
            check("illegal_resp_valid", resp_valid, 1);
            exp_st = DBG_RESP_TIMEOUT; exp_data = '0; exp_fl = '0;
        end else begin
            check("issue_valid", mst_valid, 1);
            check("issue_sel_mask", {mst_select, mst_mask}, {sel, 6'h3F});
            check("issue_op_arg", {mst_op, mst_arg}, {op, arg});
            check("issue_data", mst_data, data);
            check("issue_req_ready", req_ready, 0);

            lat_exp = (d != 0 && d + 1 <= TMO) ? d + 1 : TMO;
            if (d != 0 && d < TMO) begin
                exp_st = rsp; exp_data = rdata; exp_fl = rflags;
            end else begin
                exp_st = DBG_RESP_TIMEOUT; exp_data = '0; exp_fl = '0;
            end

            lat = -1;
            for (int k = 1; k <= TMO + 4; k++) begin
                if (lat < 0) begin
                    @(negedge clk);
                    if (resp_valid) begin
                        lat = k;
                        tgt_quiet();
                        tgt_attention = a0;
                    end else begin
                        check("wait_no_pulse", mst_valid, 0);
                        check("wait_sel_mask", {mst_select, mst_mask, req_ready}, {sel, 6'h3F, 1'b0});
                        tgt_quiet();
                        // Attention wiggles while the bus is busy must be ignored
                        tgt_attention = 1'($urandom_range(0, 1));
                        if (k == d) begin
                            tgt_valid = 1'b1; tgt_selected = sel; tgt_resp = rsp; tgt_data = rdata;
                            {tgt_hbp, tgt_resumed, tgt_halted} = rflags;
                            tgt_none = (op == 4'd0);
                        end else if (k == stray) begin
                            tgt_valid = 1'b1; tgt_selected = stray_sel; tgt_resp = 2'($urandom);
                            tgt_data = $urandom; {tgt_hbp, tgt_resumed, tgt_halted} = 3'($urandom);
                        end
                    end
                end
            end
            check("latency", 32'(lat), 32'(lat_exp));
            check("resp_bus_idle", {mst_valid, mst_select, mst_mask}, 0);
        end

        check("resp_status", resp_status, exp_st);
        check("resp_data", resp_data, exp_data);
        check("resp_flags", resp_flags, exp_fl);
        check("attn_held", attention, a0);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("resp_hold", {resp_valid, req_ready}, 2'b10);
            check("resp_hold_data", resp_data, exp_data);
        end

        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_done", {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_select = '0; req_op = '0; req_arg = '0; req_data = '0;
        resp_ready = 1'b0;
        tgt_attention = 1'b0;
        tgt_quiet();
        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);

        // CONTROL halt to target 5, reply after one cycle, response held 4 cycles
        run_txn(6'd5, 4'd1, 16'h0001, 32'h0, 1, 2'd0, 32'h0, 3'b001, 0, 4);
        // WRITE_DATA0 to target 2 with echoed data
        run_txn(6'd2, 4'd2, 16'h0000, 32'hDEADBEEF, 3, 2'd0, 32'hDEADBEEF, 3'b000, 0, 3);
        // Silent target with a stray reply from target 7
        run_txn(6'd3, 4'd1, 16'h0002, 32'h0, 0, 2'd0, 32'h0, 3'b000, 6, 1);
        // Illegal select
        run_txn(6'd0, 4'd1, 16'h0001, 32'h12345678, 0, 2'd0, 32'h0, 3'b000, 0, 2);
        // Reply on the very last cycle before the timeout wins
        run_txn(6'd63, 4'd9, 16'hBEEF, 32'hCAFEF00D, TMO - 1, 2'd2, 32'h0BAD0BAD, 3'b101, 4, 0);

        // Reset in the middle of WAIT abandons the op
        req_valid = 1'b1; req_select = 6'd4; req_op = 4'd1; req_arg = 16'h1; req_data = '0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tgt_attention = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midop_reset");
        reset = 1'b0;
        tgt_attention = 1'b0;
        @(negedge clk);
        run_txn(6'd4, 4'd1, 16'h0002, 32'h0, 2, 2'd1, 32'h55AA55AA, 3'b010, 0, 1);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            logic [5:0] s;
            int         d;
            int         st;
            s = (($urandom_range(0, 7)) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            case ($urandom_range(0, 3))
                0:       d = 0;
                1:       d = $urandom_range(TMO, TMO + 3);
                default: d = $urandom_range(1, TMO - 1);
            endcase
            st = $urandom_range(0, TMO - 1);
            if (st == d) st = 0;
            run_txn(s, 4'($urandom), 16'($urandom), $urandom, d, 2'($urandom), $urandom,
                    3'($urandom), st, $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
